// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with a registered fill level, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode.
// FWFT=1 presents the head entry combinationally. FWFT=0 registers the read
// data and pulses o_rd_valid for one cycle after each accepted read.
module sync_fifo_lvl #(
    parameter int DW     = 8,
    parameter int FW     = 64,
    parameter int AF_LVL = FW - 4,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_wr_en,
    input  logic [DW-1:0]          i_wr_data,
    output logic                   o_full,
    output logic                   o_almost_full,
    input  logic                   i_rd,
    output logic [DW-1:0]          o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_empty,
    output logic                   o_almost_empty,
    output logic [$clog2(FW):0]    o_level,
    input  logic                   i_clr_err,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    localparam int AW = $clog2(FW);
    localparam int LW = AW + 1;

    // Storage and state start at the reset state for FPGA power-up.
    logic [DW-1:0] mem_q [FW] = '{default: '0};
    logic [LW-1:0] wr_ptr_q = '0;
    logic [LW-1:0] rd_ptr_q = '0;
    logic [LW-1:0] level_q  = '0;
    logic          ovf_q    = 1'b0;
    logic          unf_q    = 1'b0;

    logic [LW-1:0] wr_ptr_d;
    logic [LW-1:0] rd_ptr_d;
    logic [LW-1:0] level_d;
    logic          ovf_d;
    logic          unf_d;

    logic          full_s;
    logic          empty_s;
    logic          wr_ok_s;
    logic          rd_ok_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] rd_idx_s;

    // Full/empty look only at the current level, so a concurrent read never
    // rescues a write into a full FIFO (and vice versa).
    assign full_s   = (level_q == LW'(FW));
    assign empty_s  = (level_q == {LW{1'b0}});
    assign wr_ok_s  = i_wr_en & ~full_s  & ~i_flush & ~i_reset;
    assign rd_ok_s  = i_rd    & ~empty_s & ~i_flush & ~i_reset;
    assign wr_idx_s = wr_ptr_q[AW-1:0];
    assign rd_idx_s = rd_ptr_q[AW-1:0];

    assign o_full         = full_s;
    assign o_empty        = empty_s;
    assign o_level        = level_q;
    assign o_almost_full  = (level_q >= LW'(AF_LVL));
    assign o_almost_empty = (level_q <= LW'(AE_LVL));
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

    // Next-state for pointers, level and sticky errors; reset dominates flush.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (i_reset) begin
            wr_ptr_d = {LW{1'b0}};
            rd_ptr_d = {LW{1'b0}};
            level_d  = {LW{1'b0}};
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (i_flush) begin
            // Contents discarded, same-cycle requests ignored, errors kept.
            wr_ptr_d = {LW{1'b0}};
            rd_ptr_d = {LW{1'b0}};
            level_d  = {LW{1'b0}};
            ovf_d    = ovf_q & ~i_clr_err;
            unf_d    = unf_q & ~i_clr_err;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + {{(LW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + {{(LW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
                default: level_d = level_q;
            endcase
            // A new error event wins over a same-cycle clear.
            ovf_d = (i_wr_en & full_s)  | (ovf_q & ~i_clr_err);
            unf_d = (i_rd    & empty_s) | (unf_q & ~i_clr_err);
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
    end

    // Storage write port; contents survive reset and flush.
    always_ff @(posedge i_clk) begin
        if (wr_ok_s) begin
            mem_q[wr_idx_s] <= i_wr_data;
        end else begin
            mem_q[wr_idx_s] <= mem_q[wr_idx_s];
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_rd_data  = mem_q[rd_idx_s];
            assign o_rd_valid = ~empty_s;
        end else begin : g_reg
            logic [DW-1:0] rd_data_q  = '0;
            logic          rd_valid_q = 1'b0;

            // Registered read port: data captured on an accepted read, held
            // otherwise; valid pulses for exactly one cycle.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    rd_data_q  <= {DW{1'b0}};
                    rd_valid_q <= 1'b0;
                end else if (rd_ok_s) begin
                    rd_data_q  <= mem_q[rd_idx_s];
                    rd_valid_q <= 1'b1;
                end else begin
                    rd_data_q  <= rd_data_q;
                    rd_valid_q <= 1'b0;
                end
            end

            assign o_rd_data  = rd_data_q;
            assign o_rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench: an FWFT instance and a registered-read instance driven by
// the same stimulus, FW=8, AF_LVL=4, AE_LVL=2.
module tb_sync_fifo_lvl;

    localparam int DW = 8;
    localparam int FW = 8;

    logic          clk_s = 1'b0;
    logic          reset_s, flush_s, wr_en_s, rd_s, clr_err_s;
    logic [DW-1:0] wr_data_s;

    logic          full0_s, af0_s, valid0_s, empty0_s, ae0_s, ovf0_s, unf0_s;
    logic [DW-1:0] data0_s;
    logic [3:0]    level0_s;
    logic          full1_s, af1_s, valid1_s, empty1_s, ae1_s, ovf1_s, unf1_s;
    logic [DW-1:0] data1_s;
    logic [3:0]    level1_s;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo_lvl #(.DW(DW), .FW(FW), .AF_LVL(4), .AE_LVL(2), .FWFT(1)) u_fwft (
        .i_clk(clk_s), .i_reset(reset_s), .i_flush(flush_s),
        .i_wr_en(wr_en_s), .i_wr_data(wr_data_s),
        .o_full(full0_s), .o_almost_full(af0_s),
        .i_rd(rd_s), .o_rd_data(data0_s), .o_rd_valid(valid0_s),
        .o_empty(empty0_s), .o_almost_empty(ae0_s), .o_level(level0_s),
        .i_clr_err(clr_err_s), .o_overflow(ovf0_s), .o_underflow(unf0_s)
    );

    sync_fifo_lvl #(.DW(DW), .FW(FW), .AF_LVL(4), .AE_LVL(2), .FWFT(0)) u_regrd (
        .i_clk(clk_s), .i_reset(reset_s), .i_flush(flush_s),
        .i_wr_en(wr_en_s), .i_wr_data(wr_data_s),
        .o_full(full1_s), .o_almost_full(af1_s),
        .i_rd(rd_s), .o_rd_data(data1_s), .o_rd_valid(valid1_s),
        .o_empty(empty1_s), .o_almost_empty(ae1_s), .o_level(level1_s),
        .i_clr_err(clr_err_s), .o_overflow(ovf1_s), .o_underflow(unf1_s)
    );

    // Free-running clock.
    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en_s = 1'b1; wr_data_s = d;
        step();
        wr_en_s = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_val(tag, {24'h0, data0_s}, {24'h0, exp});
        rd_s = 1'b1;
        step();
        rd_s = 1'b0;
    endtask

    initial begin
        reset_s = 1'b1; flush_s = 1'b0; wr_en_s = 1'b0; rd_s = 1'b0;
        clr_err_s = 1'b0; wr_data_s = 8'h00;
        step(); step();
        reset_s = 1'b0;

        // Reset state
        check_val("rst_level", {28'h0, level0_s}, 32'd0);
        check_val("rst_empty", {31'h0, empty0_s}, 32'd1);
        check_val("rst_full",  {31'h0, full0_s},  32'd0);
        check_val("rst_ae",    {31'h0, ae0_s},    32'd1);
        check_val("rst_af",    {31'h0, af0_s},    32'd0);
        check_val("rst_valid", {31'h0, valid0_s}, 32'd0);
        check_val("rst_ovf",   {31'h0, ovf0_s},   32'd0);
        check_val("rst_unf",   {31'h0, unf0_s},   32'd0);
        check_val("rst_valid_reg", {31'h0, valid1_s}, 32'd0);
        check_val("rst_data_reg",  {24'h0, data1_s},  32'd0);

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
            check_val("fill_level", {28'h0, level0_s}, 32'(i));
            check_val("fill_af",    {31'h0, af0_s},    (i >= 4) ? 32'd1 : 32'd0);
            check_val("fill_ae",    {31'h0, ae0_s},    (i <= 2) ? 32'd1 : 32'd0);
            check_val("fill_full",  {31'h0, full0_s},  (i == 8) ? 32'd1 : 32'd0);
        end
        push(8'h09);
        check_val("ovf_set",   {31'h0, ovf0_s},   32'd1);
        check_val("ovf_level", {28'h0, level0_s}, 32'd8);

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            check_val("drain_valid", {31'h0, valid0_s}, 32'd1);
            pop_check("drain_data", 8'(i));
        end
        check_val("drain_empty", {31'h0, empty0_s}, 32'd1);
        rd_s = 1'b1; step(); rd_s = 1'b0;
        check_val("unf_set",   {31'h0, unf0_s},   32'd1);
        check_val("unf_level", {28'h0, level0_s}, 32'd0);
        push(8'h33);
        pop_check("unf_ptr_stable", 8'h33);
        clr_err_s = 1'b1; step(); clr_err_s = 1'b0;
        check_val("clr_ovf", {31'h0, ovf0_s}, 32'd0);
        check_val("clr_unf", {31'h0, unf0_s}, 32'd0);

        // Index wrap
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 5; i++) pop_check("wrap5_data", 8'(8'h10 + i));
        for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 6; i++) pop_check("wrap6_data", 8'(8'h20 + i));
        check_val("wrap_level", {28'h0, level0_s}, 32'd0);

        // Simultaneous write+read at level 3
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        for (int k = 0; k < 10; k++) begin
            check_val("simul_data", {24'h0, data0_s}, 32'(8'h40 + k));
            wr_en_s = 1'b1; wr_data_s = 8'(8'h43 + k); rd_s = 1'b1;
            step();
            check_val("simul_level", {28'h0, level0_s}, 32'd3);
        end
        wr_en_s = 1'b0; rd_s = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        check_val("simul_full", {31'h0, full0_s}, 32'd1);
        check_val("full_head", {24'h0, data0_s}, 32'h4A);
        wr_en_s = 1'b1; wr_data_s = 8'h99; rd_s = 1'b1;
        step();
        wr_en_s = 1'b0; rd_s = 1'b0;
        check_val("full_wr_rd_level", {28'h0, level0_s}, 32'd7);
        check_val("full_wr_rd_ovf",   {31'h0, ovf0_s},   32'd1);
        check_val("full_wr_rd_head",  {24'h0, data0_s},  32'h4B);

        // Registered read mode
        reset_s = 1'b1; step(); reset_s = 1'b0;
        check_val("reg_rst_data", {24'h0, data1_s}, 32'd0);
        push(8'hA5);
        check_val("reg_pre_valid", {31'h0, valid1_s}, 32'd0);
        rd_s = 1'b1; step(); rd_s = 1'b0;
        check_val("reg_valid_t1", {31'h0, valid1_s}, 32'd1);
        check_val("reg_data_t1",  {24'h0, data1_s},  32'hA5);
        step();
        check_val("reg_valid_t2", {31'h0, valid1_s}, 32'd0);
        check_val("reg_data_hold", {24'h0, data1_s}, 32'hA5);

        // Error set beats clear, then clear alone
        rd_s = 1'b1; step(); rd_s = 1'b0;
        check_val("unf_set2", {31'h0, unf0_s}, 32'd1);
        rd_s = 1'b1; clr_err_s = 1'b1; step(); rd_s = 1'b0; clr_err_s = 1'b0;
        check_val("set_beats_clr", {31'h0, unf0_s}, 32'd1);
        clr_err_s = 1'b1; step(); clr_err_s = 1'b0;
        check_val("clr_only", {31'h0, unf0_s}, 32'd0);
        rd_s = 1'b1; step(); rd_s = 1'b0;

        // Flush at level 5 with concurrent write
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        check_val("pre_flush_level", {28'h0, level0_s}, 32'd5);
        flush_s = 1'b1; wr_en_s = 1'b1; wr_data_s = 8'h77;
        step();
        flush_s = 1'b0; wr_en_s = 1'b0;
        check_val("flush_level", {28'h0, level0_s}, 32'd0);
        check_val("flush_empty", {31'h0, empty0_s}, 32'd1);
        check_val("flush_unf_kept", {31'h0, unf0_s}, 32'd1);
        check_val("flush_valid", {31'h0, valid0_s}, 32'd0);

        // Reset with sticky errors set, other requests asserted
        for (int i = 0; i < 9; i++) push(8'(8'h80 + i));
        check_val("pre_rst_ovf", {31'h0, ovf0_s}, 32'd1);
        reset_s = 1'b1; flush_s = 1'b1; wr_en_s = 1'b1; rd_s = 1'b1; wr_data_s = 8'hEE;
        step();
        reset_s = 1'b0; flush_s = 1'b0; wr_en_s = 1'b0; rd_s = 1'b0;
        check_val("rst2_ovf",   {31'h0, ovf0_s},   32'd0);
        check_val("rst2_unf",   {31'h0, unf0_s},   32'd0);
        check_val("rst2_level", {28'h0, level0_s}, 32'd0);
        check_val("rst2_empty", {31'h0, empty0_s}, 32'd1);
        check_val("rst2_full",  {31'h0, full0_s},  32'd0);
        check_val("rst2_af",    {31'h0, af0_s},    32'd0);
        check_val("rst2_ae",    {31'h0, ae0_s},    32'd1);
        check_val("rst2_valid_reg", {31'h0, valid1_s}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
